// File: rtl/pacman_motion_ctrl.sv
// Per-frame Pacman movement sequencer: turn/forward wall checks over a
// req/ack lookup, committed position, facing and animation frame.
module pacman_motion_ctrl #(
    parameter int SCALE    = 2,
    parameter int STEP     = 1,
    parameter int MOVE_DIV = 1,
    parameter int ANIM_DIV = 5,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 640 - 16 * SCALE,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 480 - 16 * SCALE,
    parameter int START_X  = 304,
    parameter int START_Y  = 224
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] dir_req,
    output logic       wall_req,
    output logic [9:0] wall_x,
    output logic [9:0] wall_y,
    input  logic       wall_ack,
    input  logic       wall_hit,
    output logic [9:0] pac_x,
    output logic [9:0] pac_y,
    output logic [1:0] direction,
    output logic [1:0] frame_select,
    output logic       moving,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CHECK_TURN, CHECK_FWD} state_t;

    localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_DIV - 1);
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);

    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    state_t           state;
    logic [MW-1:0]    move_cnt;
    logic [AW-1:0]    anim_cnt;
    logic [1:0]       pend_dir;
    logic             pend_valid;
    logic [1:0]       try_dir;
    logic             oob;

    logic [1:0]       new_dir;
    logic [1:0]       sel_dir;
    logic signed [10:0] cand_x;
    logic signed [10:0] cand_y;
    logic             cand_ok;
    logic             resolve;
    logic             blocked;
    logic             launch;

    always_comb begin
        new_dir = DIR_DOWN;
        priority case (1'b1)
            dir_req[0]: new_dir = DIR_UP;
            dir_req[1]: new_dir = DIR_LEFT;
            dir_req[2]: new_dir = DIR_RIGHT;
            default:    new_dir = DIR_DOWN;
        endcase
    end

    // In IDLE a pending turn is tried first; otherwise the facing direction.
    always_comb begin
        sel_dir = (state == IDLE && pend_valid) ? pend_dir : direction;
        cand_x  = signed'({1'b0, pac_x});
        cand_y  = signed'({1'b0, pac_y});
        unique case (sel_dir)
            DIR_UP:    cand_y = cand_y - STEP_S;
            DIR_RIGHT: cand_x = cand_x + STEP_S;
            DIR_LEFT:  cand_x = cand_x - STEP_S;
            default:   cand_y = cand_y + STEP_S;
        endcase
        cand_ok = (cand_x >= XMIN_S) && (cand_x <= XMAX_S)
               && (cand_y >= YMIN_S) && (cand_y <= YMAX_S);
    end

    assign resolve = oob || (wall_req && wall_ack);
    assign blocked = oob || wall_hit;
    assign launch  = (state == IDLE && frame_tick && move_cnt == MOVE_LAST)
                  || (state == CHECK_TURN && resolve && blocked);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            move_cnt     <= '0;
            anim_cnt     <= '0;
            pend_dir     <= DIR_UP;
            pend_valid   <= 1'b0;
            try_dir      <= DIR_UP;
            oob          <= 1'b0;
            wall_req     <= 1'b0;
            wall_x       <= '0;
            wall_y       <= '0;
            pac_x        <= 10'(START_X);
            pac_y        <= 10'(START_Y);
            direction    <= DIR_RIGHT;
            frame_select <= 2'd0;
            moving       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            if (frame_tick && moving) begin
                if (anim_cnt == ANIM_LAST) begin
                    anim_cnt     <= '0;
                    frame_select <= frame_select + 2'd1;
                end else begin
                    anim_cnt <= anim_cnt + 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (frame_tick) begin
                        if (move_cnt == MOVE_LAST) begin
                            move_cnt <= '0;
                            state    <= pend_valid ? CHECK_TURN : CHECK_FWD;
                            busy     <= 1'b1;
                            try_dir  <= sel_dir;
                        end else begin
                            move_cnt <= move_cnt + 1'b1;
                        end
                    end
                end
                CHECK_TURN, CHECK_FWD: begin
                    if (resolve) begin
                        wall_req <= 1'b0;
                        if (!blocked) begin
                            pac_x  <= wall_x;
                            pac_y  <= wall_y;
                            moving <= 1'b1;
                            state  <= IDLE;
                            busy   <= 1'b0;
                            if (state == CHECK_TURN) begin
                                direction  <= try_dir;
                                pend_valid <= 1'b0;
                            end
                        end else if (state == CHECK_TURN) begin
                            state <= CHECK_FWD;
                        end else begin
                            moving <= 1'b0;
                            state  <= IDLE;
                            busy   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Out-of-bounds candidates skip the query and resolve as a hit.
            if (launch) begin
                wall_req <= cand_ok;
                oob      <= !cand_ok;
                if (cand_ok) begin
                    wall_x <= cand_x[9:0];
                    wall_y <= cand_y[9:0];
                end
            end

            if (|dir_req) begin
                pend_dir   <= new_dir;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Bench for pacman_motion_ctrl: directed timing scenarios plus a random
// walk through a synthetic maze checked against a behavioural model.
module tb_pacman_motion_ctrl;

    localparam int XMAX = 608;
    localparam int YMAX = 448;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [3:0] dir_req = 4'd0;
    logic       wall_req;
    logic [9:0] wall_x;
    logic [9:0] wall_y;
    logic       wall_ack = 1'b0;
    logic       wall_hit = 1'b0;
    logic [9:0] pac_x;
    logic [9:0] pac_y;
    logic [1:0] direction;
    logic [1:0] frame_select;
    logic       moving;
    logic       busy;

    int errors = 0;
    int checks = 0;

    bit resp_en = 1'b0;
    int resp_wait = 0;
    int hit_mode = 0;
    int att_q = 0;
    int wcnt = 0;
    int req_cycles = 0;
    logic [19:0] qlog[$];

    pacman_motion_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .dir_req(dir_req),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
        .wall_ack(wall_ack), .wall_hit(wall_hit),
        .pac_x(pac_x), .pac_y(pac_y), .direction(direction),
        .frame_select(frame_select), .moving(moving), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit maze(input int x, input int y);
        return ((x * 3 + y * 5) % 7) == 0;
    endfunction

    // Maze responder: answers after resp_wait idle cycles of an open request.
    always @(negedge clk) begin
        if (resp_en) begin
            if (wall_ack) wcnt = 0;
            if (wall_req && !rst && wcnt >= resp_wait) begin
                wall_ack = 1'b1;
                wall_hit = (hit_mode == 1) || (hit_mode == 2 && att_q == 0)
                        || (hit_mode == 3 && maze(int'(wall_x), int'(wall_y)));
                att_q++;
                qlog.push_back({wall_x, wall_y});
            end else begin
                wall_ack = 1'b0;
                wall_hit = 1'b0;
                if (wall_req) wcnt++;
            end
        end
        if (wall_req) req_cycles++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        frame_tick = 1'b0;
        dir_req = 4'd0;
        resp_en = 1'b0;
        wall_ack = 1'b0;
        wall_hit = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_dir(input logic [3:0] r);
        @(negedge clk);
        dir_req = r;
        @(negedge clk);
        dir_req = 4'd0;
    endtask

    task automatic do_tick();
        int n;
        n = 0;
        qlog.delete();
        req_cycles = 0;
        att_q = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({pac_x, pac_y, direction, frame_select, moving, wall_req, busy}
            !== {10'd304, 10'd224, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: x=%0d y=%0d dir=%0d fs=%0d mv=%0b req=%0b busy=%0b required 304/224/1/0/0/0/0",
                     pac_x, pac_y, direction, frame_select, moving, wall_req, busy);
        end
    endtask

    task automatic test_free_move();
        @(negedge clk);
        frame_tick = 1'b1;
        wall_ack = 1'b1;
        wall_hit = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
        checks++;
        if ({busy, wall_req, wall_x, wall_y} !== {1'b1, 1'b1, 10'd305, 10'd224}) begin
            errors++;
            $display("FAIL free_query: busy=%0b req=%0b wx=%0d wy=%0d required 1/1/305/224",
                     busy, wall_req, wall_x, wall_y);
        end
        @(negedge clk);
        checks++;
        if ({busy, wall_req, pac_x, pac_y, moving, direction}
            !== {1'b0, 1'b0, 10'd305, 10'd224, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL free_commit: busy=%0b req=%0b x=%0d y=%0d mv=%0b dir=%0d required 0/0/305/224/1/1",
                     busy, wall_req, pac_x, pac_y, moving, direction);
        end
        wall_ack = 1'b0;
    endtask

    task automatic test_turn();
        do_reset();
        resp_en = 1'b1;
        resp_wait = 0;
        hit_mode = 0;
        pulse_dir(4'b0101);
        do_tick();
        checks++;
        if ({direction, pac_x, pac_y, moving} !== {2'd0, 10'd304, 10'd223, 1'b1}) begin
            errors++;
            $display("FAIL turn_up: dir=%0d x=%0d y=%0d mv=%0b required 0/304/223/1",
                     direction, pac_x, pac_y, moving);
        end
        checks++;
        if (req_cycles != 1 || qlog.size() != 1 || qlog[0] !== {10'd304, 10'd223}) begin
            errors++;
            $display("FAIL turn_query: req_cycles=%0d queries=%0d required 1 query at 304,223",
                     req_cycles, qlog.size());
        end
        hit_mode = 1;
        do_tick();
        checks++;
        if (req_cycles != 1 || moving !== 1'b0 || pac_y !== 10'd223) begin
            errors++;
            $display("FAIL turn_cleared: req_cycles=%0d mv=%0b y=%0d required 1/0/223",
                     req_cycles, moving, pac_y);
        end
        hit_mode = 0;
        pulse_dir(4'b1110);
        do_tick();
        checks++;
        if ({direction, pac_x, pac_y} !== {2'd2, 10'd303, 10'd223}) begin
            errors++;
            $display("FAIL turn_left_prio: dir=%0d x=%0d y=%0d required 2/303/223",
                     direction, pac_x, pac_y);
        end
    endtask

    task automatic test_turn_blocked();
        do_reset();
        resp_en = 1'b1;
        resp_wait = 0;
        hit_mode = 2;
        pulse_dir(4'b0001);
        qlog.delete();
        att_q = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checks++;
        if ({wall_req, wall_x, wall_y} !== {1'b1, 10'd304, 10'd223}) begin
            errors++;
            $display("FAIL blocked_q1: req=%0b wx=%0d wy=%0d required 1/304/223",
                     wall_req, wall_x, wall_y);
        end
        @(negedge clk);
        checks++;
        if ({wall_req, wall_x, wall_y, busy} !== {1'b1, 10'd305, 10'd224, 1'b1}) begin
            errors++;
            $display("FAIL blocked_q2: req=%0b wx=%0d wy=%0d busy=%0b required 1/305/224/1",
                     wall_req, wall_x, wall_y, busy);
        end
        @(negedge clk);
        checks++;
        if ({busy, pac_x, pac_y, direction, moving}
            !== {1'b0, 10'd305, 10'd224, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL blocked_commit: busy=%0b x=%0d y=%0d dir=%0d mv=%0b required 0/305/224/1/1",
                     busy, pac_x, pac_y, direction, moving);
        end
        hit_mode = 0;
        do_tick();
        checks++;
        if ({direction, pac_x, pac_y} !== {2'd0, 10'd305, 10'd223} || qlog.size() != 1) begin
            errors++;
            $display("FAIL turn_retry: dir=%0d x=%0d y=%0d queries=%0d required 0/305/223/1",
                     direction, pac_x, pac_y, qlog.size());
        end
    endtask

    task automatic test_bounds();
        do_reset();
        resp_en = 1'b1;
        resp_wait = 0;
        hit_mode = 0;
        for (int i = 0; i < XMAX - 304; i++) do_tick();
        checks++;
        if (pac_x !== 10'(XMAX)) begin
            errors++;
            $display("FAIL reach_xmax: x=%0d required %0d", pac_x, XMAX);
        end
        do_tick();
        checks++;
        if (req_cycles != 0 || moving !== 1'b0 || pac_x !== 10'(XMAX)) begin
            errors++;
            $display("FAIL bound_right: req_cycles=%0d mv=%0b x=%0d required 0/0/%0d",
                     req_cycles, moving, pac_x, XMAX);
        end
        pulse_dir(4'b0010);
        for (int i = 0; i < XMAX; i++) do_tick();
        checks++;
        if (pac_x !== 10'd0 || direction !== 2'd2) begin
            errors++;
            $display("FAIL reach_xmin: x=%0d dir=%0d required 0/2", pac_x, direction);
        end
        do_tick();
        checks++;
        if (req_cycles != 0 || moving !== 1'b0 || pac_x !== 10'd0) begin
            errors++;
            $display("FAIL bound_left: req_cycles=%0d mv=%0b x=%0d required 0/0/0",
                     req_cycles, moving, pac_x);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        resp_en = 1'b1;
        resp_wait = 0;
        hit_mode = 0;
        do_tick();
        resp_wait = 3;
        qlog.delete();
        req_cycles = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int n = 0; n < 20 && busy; n++) @(negedge clk);
        checks++;
        if (qlog.size() != 1 || req_cycles != 4 || pac_x !== 10'd306 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_tick: queries=%0d req_cycles=%0d x=%0d busy=%0b required 1/4/306/0",
                     qlog.size(), req_cycles, pac_x, busy);
        end
        resp_wait = 0;
        repeat (3) do_tick();
        checks++;
        if (frame_select !== 2'd1 || pac_x !== 10'd309) begin
            errors++;
            $display("FAIL busy_tick_anim: fs=%0d x=%0d required 1/309",
                     frame_select, pac_x);
        end
    endtask

    task automatic test_anim_reset();
        int exp_fs;
        do_reset();
        resp_en = 1'b1;
        resp_wait = 0;
        hit_mode = 0;
        for (int k = 1; k <= 20; k++) begin
            do_tick();
            exp_fs = ((k - 1) / 5) % 4;
            checks++;
            if (frame_select !== 2'(exp_fs)) begin
                errors++;
                $display("FAIL anim_tick%0d: fs=%0d required %0d", k, frame_select, exp_fs);
            end
        end
        resp_en = 1'b0;
        wall_ack = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checks++;
        if (wall_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_req: req=%0b required 1", wall_req);
        end
        rst = 1'b1;
        wall_ack = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            rst = 1'b0;
            wall_ack = 1'b0;
            checks++;
            if ({pac_x, pac_y, direction, frame_select, moving, wall_req, wall_x, wall_y, busy}
                !== {10'd304, 10'd224, 2'd1, 2'd0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0}) begin
                errors++;
                $display("FAIL mid_reset%0d: x=%0d y=%0d dir=%0d fs=%0d mv=%0b req=%0b wx=%0d wy=%0d busy=%0b required reset values",
                         r, pac_x, pac_y, direction, frame_select, moving, wall_req,
                         wall_x, wall_y, busy);
            end
        end
    endtask

    task automatic step(input int x, input int y, input int d,
                        output int nx, output int ny, output bit ok);
        nx = x;
        ny = y;
        case (d)
            0: ny = y - 1;
            1: nx = x + 1;
            2: nx = x - 1;
            default: ny = y + 1;
        endcase
        ok = nx >= 0 && nx <= XMAX && ny >= 0 && ny <= YMAX;
    endtask

    task automatic test_random();
        int mx, my, md, mpd, manim, mframe, nx, ny;
        bit mpv, mmov, ok, done, qok;
        logic [3:0] r;
        logic [19:0] eq[$];
        do_reset();
        resp_en = 1'b1;
        hit_mode = 3;
        mx = 304; my = 224; md = 1; mpd = 0;
        manim = 0; mframe = 0; mpv = 0; mmov = 0;
        for (int i = 0; i < 150; i++) begin
            resp_wait = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                r = 4'($urandom_range(1, 15));
                pulse_dir(r);
                mpv = 1;
                mpd = r[0] ? 0 : r[1] ? 2 : r[2] ? 1 : 3;
            end
            eq.delete();
            if (mmov) begin
                manim++;
                if (manim == 5) begin
                    manim = 0;
                    mframe = (mframe + 1) % 4;
                end
            end
            done = 0;
            if (mpv) begin
                step(mx, my, mpd, nx, ny, ok);
                if (ok) eq.push_back({10'(nx), 10'(ny)});
                if (ok && !maze(nx, ny)) begin
                    mx = nx; my = ny; md = mpd;
                    mpv = 0; mmov = 1; done = 1;
                end
            end
            if (!done) begin
                step(mx, my, md, nx, ny, ok);
                if (ok) eq.push_back({10'(nx), 10'(ny)});
                if (ok && !maze(nx, ny)) begin
                    mx = nx; my = ny; mmov = 1;
                end else begin
                    mmov = 0;
                end
            end
            do_tick();
            checks++;
            if ({pac_x, pac_y, direction, moving, frame_select}
                !== {10'(mx), 10'(my), 2'(md), mmov, 2'(mframe)}) begin
                errors++;
                $display("FAIL rand%0d: x=%0d y=%0d dir=%0d mv=%0b fs=%0d required %0d/%0d/%0d/%0b/%0d",
                         i, pac_x, pac_y, direction, moving, frame_select,
                         mx, my, md, mmov, mframe);
            end
            qok = (qlog.size() == eq.size());
            for (int j = 0; j < eq.size() && qok; j++)
                if (qlog[j] !== eq[j]) qok = 0;
            checks++;
            if (!qok) begin
                errors++;
                $display("FAIL rand%0d_queries: got %0d queries required %0d", i,
                         qlog.size(), eq.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_move();
        test_turn();
        test_turn_blocked();
        test_bounds();
        test_back_to_back();
        test_anim_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pacman_motion_ctrl.md
# pacman_motion_ctrl

Per-frame movement and animation sequencer for the Pacman sprite. Once per video frame it latches the player's direction request, checks the candidate position against screen bounds and the maze wall lookup through a req/ack handshake, and commits the new position, facing direction and animation frame. Its outputs drive the pixel-drawing block, which reads `pac_x`, `pac_y`, `direction` and `frame_select` and never writes them.

## Interface
- `SCALE`, 2: sprite magnification; sprite footprint is 16*SCALE pixels square.
- `STEP`, 1: pixels moved per committed move (1..15).
- `MOVE_DIV`, 1: frame ticks per movement attempt (≥1).
- `ANIM_DIV`, 5: frame ticks per animation frame advance while moving (≥1).
- `X_MIN`, 0 / `X_MAX`, 640-16*SCALE: legal range of `pac_x`, inclusive.
- `Y_MIN`, 0 / `Y_MAX`, 480-16*SCALE: legal range of `pac_y`, inclusive.
- `START_X`, 304 / `START_Y`, 224: position loaded at reset.

- `clk`  in  1  pixel clock (25 MHz domain).
- `rst`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse at the start of vertical blank (yPix=480, xPix=0).
- `dir_req`  in  4  debounced buttons: bit0 up, bit1 left, bit2 right, bit3 down.
- `wall_req`  out  1  wall lookup request, registered.
- `wall_x`, `wall_y`  out  10 each  candidate top-left position under query.
- `wall_ack`  in  1  lookup complete; `wall_hit` is valid in the same cycle.
- `wall_hit`  in  1  1 = candidate overlaps a wall.
- `pac_x`, `pac_y`  out  10 each  committed sprite top-left position.
- `direction`  out  2  0 up, 1 right, 2 left, 3 down.
- `frame_select`  out  2  sprite animation frame.
- `moving`  out  1  1 = the last movement attempt committed.
- `busy`  out  1  1 = state is not IDLE.

## Operation
- Request latch, every cycle: if any `dir_req` bit is set, `pend_dir` is loaded with priority up > left > right > down, and `pend_valid` is set to 1. A newer request overwrites an older one. `pend_valid` clears only when a turn commits.
- FSM states: IDLE, CHECK_TURN, CHECK_FWD.
- IDLE, on `frame_tick`:
  - `move_cnt` increments.
  - If `move_cnt == MOVE_DIV-1`, it wraps to 0 and the FSM goes to CHECK_TURN when `pend_valid` is set, otherwise to CHECK_FWD.
  - Otherwise the FSM stays in IDLE.
- Candidate: the current position offset by STEP in the tested direction (up -y, down +y, left -x, right +x). It is computed at 11 bits signed, so underflow is detectable.
- Out-of-bounds candidate (outside [X_MIN,X_MAX] or [Y_MIN,Y_MAX]): treated as a hit with no query issued, and the state resolves in 1 cycle.
- In-bounds candidate:
  - `wall_req` is driven to 1 with `wall_x`/`wall_y` set to the candidate. Request and coordinates stay stable until `wall_ack` is sampled high.
  - `wall_ack` is honoured in any cycle where `wall_req` is 1, including the first. `wall_ack` while `wall_req` is 0 is ignored.
  - `wall_req` drops on the edge after ack.
- CHECK_TURN outcomes:
  - Free: commit the candidate to `pac_x`/`pac_y`, set `direction <= pend_dir`, clear `pend_valid`, set `moving <= 1`, go to IDLE.
  - Hit: keep `pend_valid`, go to CHECK_FWD.
- CHECK_FWD outcomes:
  - Free: commit the candidate and set `moving <= 1`.
  - Hit: set `moving <= 0`.
  - Either way, go to IDLE. `direction` is unchanged.
- Animation, on every `frame_tick` in any state, when `moving` = 1:
  - `anim_cnt` increments.
  - At `ANIM_DIV-1`, it wraps to 0 and `frame_select` increments (3 wraps to 0).
  - When `moving` = 0, `anim_cnt` and `frame_select` hold.
- A `frame_tick` arriving while `busy` does not start a new attempt and does not advance `move_cnt`. Animation still counts it.
- Reset, including mid-handshake:
  - `pac_x`=START_X, `pac_y`=START_Y.
  - `direction`=1, `frame_select`=0, `moving`=0.
  - `wall_req`=0, `wall_x`=`wall_y`=0, `busy`=0, state IDLE.
  - `pend_valid`=0, `move_cnt`=0, `anim_cnt`=0.
  - A `wall_ack` pending at reset is discarded.

## Timing
- `frame_tick` at edge T: state changes at T+1, and `wall_req`/`busy` are high in cycle T+1.
- With a zero-wait responder (ack in T+1), position and direction are visible at T+2 and `busy` falls at T+2.
- Turn blocked, then forward check: the second `wall_req` is high at T+2 with a zero-wait responder, and the commit is visible at T+3.
- A responder with W wait cycles adds W cycles per query.
- Every output is registered; there are no combinational paths from inputs to outputs.
- All commits land during vertical blank, provided the total handshake latency stays under 45 lines (36000 clocks). The drawing block therefore sees a position that is constant for the whole visible frame.

## Test plan
- Reset with `START_X`=304, `START_Y`=224: after `rst` deasserts, outputs read 304/224, `direction`=1, `frame_select`=0, `moving`=0 and `wall_req`=0.
- No request, free path: a `frame_tick` with `wall_ack`=1/`wall_hit`=0 the same cycle gives `pac_x`=305 two cycles later, `moving`=1 and `busy` high for exactly 1 cycle.
- Turn request up while at (304,224), both free: `direction`=0, `pac_y`=223 and `pend_valid` cleared. Only one `wall_req` cycle, with `wall_x`=304 and `wall_y`=223.
- Turn blocked (first ack has `wall_hit`=1), forward free: a second query at (305,224) follows. Result: `direction` stays 1, `pac_x`=305, and the pending turn is retried on the next tick.
- Bounds: `pac_x`=X_MAX facing right yields no `wall_req` and `moving`=0. With `pac_x`=0 facing left, no query is issued (the 11-bit underflow is caught).
- Animation plus reset: with `ANIM_DIV`=5 and continuous free moves, `frame_select` steps 0→1→2→3→0 every 5 ticks. Asserting `rst` while `wall_req`=1 drops `wall_req` on the next edge and restores every reset value.
